// File: rtl/ifetch_unit.sv
// Instruction fetch front end: walks a fetch PC through instruction memory and
// queues {pc, instruction} pairs in a small fall-through buffer for the decoder.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 4,
    parameter int          MEM_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_ins,
    output logic        fault
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t            state;
    logic [31:0]       fetch_pc;
    logic [PTR_W-1:0]  read_ptr;
    logic [PTR_W-1:0]  write_ptr;
    logic [CNT_W-1:0]  count;

    logic [31:0]       buf_pc  [DEPTH];
    logic [31:0]       buf_ins [DEPTH];

    logic              pop;
    logic              slot;
    logic              pc_bad;
    logic              push;
    logic              to_fault;

    assign imem_addr = {2'b00, fetch_pc[31:2]};

    assign out_valid = (count != '0);
    assign out_pc    = buf_pc[read_ptr];
    assign out_ins   = buf_ins[read_ptr];

    assign pop = out_valid && out_ready;

    // A fetch slot exists whenever a push would be legal; a bad PC turns that
    // slot into the fault transition instead of a push.
    assign slot     = (state == FETCH) && !redirect_valid && ((count < FULL) || pop);
    assign pc_bad   = (fetch_pc[1:0] != 2'b00) ||
                      ({2'b00, fetch_pc[31:2]} >= 32'(MEM_WORDS));
    assign push     = slot && !pc_bad;
    assign to_fault = slot && pc_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            fault     <= 1'b0;
            fetch_pc  <= RESET_PC;
            count     <= '0;
            read_ptr  <= '0;
            write_ptr <= '0;
        end else if (redirect_valid) begin
            // Redirect flushes the buffer; a same-cycle pop has already been
            // taken by the consumer, so no bookkeeping for it is needed.
            state     <= FETCH;
            fault     <= 1'b0;
            fetch_pc  <= redirect_pc;
            count     <= '0;
            read_ptr  <= '0;
            write_ptr <= '0;
        end else begin
            if (to_fault) begin
                state <= FAULT;
                fault <= 1'b1;
            end
            if (push) begin
                write_ptr <= write_ptr + 1'b1;
                fetch_pc  <= fetch_pc + 32'd4;
            end
            if (pop) begin
                read_ptr <= read_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Buffer payload carries no reset; out_* are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            buf_pc[write_ptr]  <= fetch_pc;
            buf_ins[write_ptr] <= imem_data;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed cycle table, hand-written corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_ifetch_unit;

    localparam int          DEPTH     = 4;
    localparam int          MEM_WORDS = 512;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_ins;
    logic        fault;

    ifetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .MEM_WORDS(MEM_WORDS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_ins       (out_ins),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: word k holds the value k.
    assign imem_data = imem_addr;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Inputs applied for one cycle; outputs are sampled in that same cycle.
    task automatic drive(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #1;
    endtask

    typedef struct {
        logic        r;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        chk;
        logic        ev;
        logic [31:0] epc;
        logic        ef;
        logic [31:0] eaddr;
    } vec_t;

    function automatic vec_t mk(logic r, logic rv, logic [31:0] rpc, logic rdy, logic chk,
                                logic ev, logic [31:0] epc, logic ef, logic [31:0] eaddr);
        vec_t v;
        v.r = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.chk = chk;
        v.ev = ev; v.epc = epc; v.ef = ef; v.eaddr = eaddr;
        return v;
    endfunction

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    vec_t        tbl[$];
    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic        m_fault;

    initial begin
        logic        r, rv, rdy;
        logic [31:0] rpc;
        bit          popd, room;
        int          sel;

        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

        // Streaming from reset
        tbl.push_back(mk(1, 0, 0,      1, 0, 0, 0,      0, 0));
        tbl.push_back(mk(0, 0, 0,      1, 1, 0, 0,      0, 0));
        tbl.push_back(mk(0, 0, 0,      1, 1, 1, 0,      0, 1));
        tbl.push_back(mk(0, 0, 0,      1, 1, 1, 4,      0, 2));
        tbl.push_back(mk(0, 0, 0,      1, 1, 1, 8,      0, 3));
        // Reset again, then 10 cycles of backpressure
        tbl.push_back(mk(1, 0, 0,      0, 1, 1, 12,     0, 4));
        tbl.push_back(mk(0, 0, 0,      0, 1, 0, 0,      0, 0));
        tbl.push_back(mk(0, 0, 0,      0, 1, 1, 0,      0, 1));
        tbl.push_back(mk(0, 0, 0,      0, 1, 1, 0,      0, 2));
        tbl.push_back(mk(0, 0, 0,      0, 1, 1, 0,      0, 3));
        for (int k = 0; k < 6; k++)
            tbl.push_back(mk(0, 0, 0,  0, 1, 1, 0,      0, 4));
        // Release: full buffer with simultaneous push and pop
        tbl.push_back(mk(0, 0, 0,      1, 1, 1, 0,      0, 4));
        tbl.push_back(mk(0, 0, 0,      1, 1, 1, 4,      0, 5));
        tbl.push_back(mk(0, 0, 0,      1, 1, 1, 8,      0, 6));
        tbl.push_back(mk(0, 0, 0,      1, 1, 1, 12,     0, 7));
        // Redirect with simultaneous pop
        tbl.push_back(mk(0, 1, 'h100,  1, 1, 1, 16,     0, 8));
        tbl.push_back(mk(0, 0, 0,      1, 1, 0, 0,      0, 'h40));
        tbl.push_back(mk(0, 0, 0,      0, 1, 1, 'h100,  0, 'h41));
        // Misaligned redirect, out-of-range redirect, recovery
        tbl.push_back(mk(0, 1, 'h102,  1, 1, 1, 'h100,  0, 'h42));
        tbl.push_back(mk(0, 0, 0,      1, 1, 0, 0,      0, 'h40));
        tbl.push_back(mk(0, 0, 0,      1, 1, 0, 0,      1, 'h40));
        tbl.push_back(mk(0, 1, 'h800,  1, 1, 0, 0,      1, 'h40));
        tbl.push_back(mk(0, 0, 0,      1, 1, 0, 0,      0, 'h200));
        tbl.push_back(mk(0, 1, 'h8,    1, 1, 0, 0,      1, 'h200));
        tbl.push_back(mk(0, 0, 0,      1, 1, 0, 0,      0, 2));
        tbl.push_back(mk(0, 0, 0,      1, 1, 1, 8,      0, 3));
        tbl.push_back(mk(0, 0, 0,      1, 1, 1, 12,     0, 4));

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
            if (tbl[i].chk) begin
                check($sformatf("v%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
                check($sformatf("v%0d_fault", i), 32'(fault), 32'(tbl[i].ef));
                check($sformatf("v%0d_addr", i), imem_addr, tbl[i].eaddr);
                if (tbl[i].ev) begin
                    check($sformatf("v%0d_pc", i), out_pc, tbl[i].epc);
                    check($sformatf("v%0d_ins", i), out_ins, tbl[i].epc >> 2);
                end
            end
        end

        // Reset with three entries buffered
        drive(1, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 1);
        check("rst3_addr_before", imem_addr, 32'd3);
        check("rst3_valid_before", 32'(out_valid), 32'd1);
        drive(0, 0, 0, 1);
        check("rst3_valid_after", 32'(out_valid), 32'd0);
        check("rst3_addr_after", imem_addr, RESET_PC >> 2);
        drive(0, 0, 0, 1);
        check("rst3_valid_next", 32'(out_valid), 32'd1);
        check("rst3_pc_next", out_pc, RESET_PC);

        // Run into the memory end, then drain the buffer while faulted
        drive(0, 1, 32'h7F8, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        check("end_fault_pre", 32'(fault), 32'd0);
        drive(0, 0, 0, 1);
        check("end_fault", 32'(fault), 32'd1);
        check("end_pc0", out_pc, 32'h7F8);
        check("end_ins0", out_ins, 32'd510);
        drive(0, 0, 0, 1);
        check("end_pc1", out_pc, 32'h7FC);
        check("end_ins1", out_ins, 32'd511);
        drive(0, 0, 0, 1);
        check("end_drained", 32'(out_valid), 32'd0);
        check("end_fault_hold", 32'(fault), 32'd1);

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            r   = (i == 0) || ($urandom_range(0, 149) == 0);
            rv  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            sel = $urandom_range(0, 9);
            case (sel)
                0:       rpc = (32'($urandom_range(0, MEM_WORDS - 1)) << 2) | 32'($urandom_range(1, 3));
                1:       rpc = 32'($urandom_range(MEM_WORDS, MEM_WORDS + 200)) << 2;
                2:       rpc = 32'(MEM_WORDS - 3) << 2;
                default: rpc = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
            endcase
            drive(r, rv, rpc, rdy);

            if (i != 0) begin
                check($sformatf("r%0d_valid", i), 32'(out_valid), 32'(m_q.size() != 0));
                check($sformatf("r%0d_fault", i), 32'(fault), 32'(m_fault));
                check($sformatf("r%0d_addr", i), imem_addr, m_pc >> 2);
                if (m_q.size() != 0) begin
                    check($sformatf("r%0d_pc", i), out_pc, m_q[0].pc);
                    check($sformatf("r%0d_ins", i), out_ins, m_q[0].ins);
                end
            end

            if (r) begin
                m_q.delete();
                m_pc    = RESET_PC;
                m_fault = 1'b0;
            end else if (rv) begin
                m_q.delete();
                m_pc    = rpc;
                m_fault = 1'b0;
            end else begin
                popd = (m_q.size() != 0) && rdy;
                room = !m_fault && ((m_q.size() < DEPTH) || popd);
                if (popd) void'(m_q.pop_front());
                if (room) begin
                    if ((m_pc % 4 != 0) || (m_pc / 4 >= MEM_WORDS)) begin
                        m_fault = 1'b1;
                    end else begin
                        m_q.push_back('{pc: m_pc, ins: m_pc / 4});
                        m_pc = m_pc + 32'd4;
                    end
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address fetched first after reset.
REQ-002 Parameter DEPTH, default 4, instruction buffer entries; power of two, at least 2.
REQ-003 Parameter MEM_WORDS, default 512, instruction memory size in 32-bit words.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 imem_addr  output  32  word address to instruction memory, equal to fetch_pc >> 2.
REQ-007 imem_data  input  32  instruction word, combinationally valid in the same cycle as imem_addr.
REQ-008 redirect_valid  input  1  branch/jump redirect request, single-cycle pulse.
REQ-009 redirect_pc  input  32  redirect target byte address.
REQ-010 out_valid  output  1  out_pc/out_ins hold a valid instruction.
REQ-011 out_ready  input  1  consumer accepts the instruction when out_valid and out_ready are both 1.
REQ-012 out_pc  output  32  byte address of the presented instruction.
REQ-013 out_ins  output  32  presented instruction word.
REQ-014 fault  output  1  fetch halted on a misaligned or out-of-range PC.

Function
REQ-015 State machine: FETCH and FAULT; reset enters FETCH.
REQ-016 imem_addr shall be fetch_pc[31:2] zero-extended to 32 bits, combinational from the fetch_pc register.
REQ-017 Buffer: FIFO of {pc, ins} with first-word-fall-through; out_valid = (count != 0); out_pc/out_ins come from the head entry.
REQ-018 Pop occurs on (out_valid && out_ready); the head advances and read_ptr wraps modulo DEPTH.
REQ-019 Push occurs in FETCH when no redirect is active and (count < DEPTH or pop occurs this cycle).
REQ-020 A push writes {fetch_pc, imem_data}, advances write_ptr modulo DEPTH, and sets fetch_pc to fetch_pc + 4 (32-bit wraparound).
REQ-021 With no push, fetch_pc shall hold its value; while full with no pop, no push occurs and imem_addr stays constant.
REQ-022 count shall update as +1 on push only, -1 on pop only, and stay unchanged on both or neither; count never exceeds DEPTH.
REQ-023 Latency: an instruction fetched in cycle N shall appear on out_* in cycle N+1.
REQ-024 Sustained throughput: one instruction per cycle while out_ready is held at 1.
REQ-025 Redirect has priority over push and pop bookkeeping: count, read_ptr and write_ptr go to 0 and fetch_pc is loaded from redirect_pc. An instruction popped in the same cycle is still consumed by the consumer.
REQ-026 After a redirect in cycle N, out_valid shall be 0 in cycle N+1. The target instruction shall appear in cycle N+2.
REQ-027 Transition FETCH to FAULT when fetch_pc[1:0] != 0 or (fetch_pc >> 2) >= MEM_WORDS. Fault checks are evaluated on the fetch_pc register value, not on redirect_pc.
REQ-028 The transition to FAULT takes effect on the edge at which that push would have occurred.
REQ-029 In FAULT: no push; entries already buffered keep draining normally; fault = 1.
REQ-030 Transition FAULT to FETCH only on redirect_valid; the redirect is applied per REQ-025, and fault clears in the next cycle.
REQ-031 fault shall be registered and equal to (state == FAULT).

Reset
REQ-032 On rst = 1 at a rising edge: state = FETCH, fetch_pc = RESET_PC, count = 0, read_ptr = 0, write_ptr = 0.
REQ-033 Resulting output values: out_valid = 0, fault = 0, imem_addr = RESET_PC >> 2.
REQ-034 rst overrides redirect_valid and any push or pop in the same cycle.
REQ-035 Buffer data contents need not be cleared; out_pc and out_ins are don't-care while out_valid = 0.
REQ-036 Reset asserted mid-operation discards all buffered entries, and fetching restarts at RESET_PC in the first cycle after rst deasserts.

Verification
REQ-037 Streaming: release reset with RESET_PC = 0, memory word k = k, out_ready = 1. Required: out_valid rises one cycle after release; out_pc = 0, 4, 8, ...; out_ins = 0, 1, 2, ...; no bubbles.
REQ-038 Backpressure: hold out_ready = 0 for 10 cycles. Required: count saturates at 4; imem_addr frozen at 4; out_pc stays 0. On release, out_pc = 0, 4, 8, 12, 16 on consecutive cycles.
REQ-039 Redirect with simultaneous pop: redirect_pc = 32'h100 while out_valid = 1 and out_ready = 1. Required: the current head is consumed; next cycle out_valid = 0; following cycle out_pc = 32'h100, out_ins = word 64.
REQ-040 Faults: redirect_pc = 32'h102 gives fault = 1 after 2 cycles and no further pushes. Redirect to 32'h800 (word 512, MEM_WORDS = 512) gives fault. A redirect to 32'h8 then clears fault and streams from 8.
REQ-041 Full with simultaneous push and pop: count = 4 and out_ready = 1 for 3 cycles. Required: count stays 4, one entry popped and one pushed per cycle, pointers wrap correctly.
REQ-042 Reset mid-stream: assert rst for 1 cycle with 3 entries buffered. Required: out_valid = 0 the next cycle, then out_pc = RESET_PC.
